// File: rtl/led_sequencer_ctrl.sv
// Autonomous LED pattern sequencer: CSR slave plus write-only master into an 18-bit PIO.
// Optional build macro LED_SEQ_BLANK_ON_STOP_EN adds a BLANK step that writes 0 before idling.
module led_sequencer_ctrl #(
  parameter int unsigned DATA_W   = 18,
  parameter int unsigned PERIOD_W = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        s_address,
  input  logic              s_chipselect,
  input  logic              s_write_n,
  input  logic [31:0]       s_writedata,
  output logic [31:0]       s_readdata,
  output logic [1:0]        m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic [DATA_W-1:0] m_writedata,
  output logic              irq
);

  typedef enum logic [2:0] {
    StIdle,
    StStrobe,
    StWait,
    StEnd
`ifdef LED_SEQ_BLANK_ON_STOP_EN
    , StBlank
`endif
  } state_e;

  // State entered on CPU stop or one-shot completion.
`ifdef LED_SEQ_BLANK_ON_STOP_EN
  localparam state_e StHalt = StBlank;
`else
  localparam state_e StHalt = StIdle;
`endif

  state_e              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                run_q, run_d;
  logic                loop_q, loop_d;
  logic                irq_en_q, irq_en_d;
  logic                done_q, done_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [1:0]          length_q, length_d;
  logic [DATA_W-1:0]   pat_q [4];
  logic [DATA_W-1:0]   pat_d [4];

  logic                wr_en, ctrl_wr, status_wr, cpu_stop, busy;
  logic                set_done, end_clear;
  logic [PERIOD_W:0]   eff_period, cnt_inc;
  logic                unused_wdata;

  assign wr_en      = s_chipselect & ~s_write_n;
  assign ctrl_wr    = wr_en && (s_address == 3'd0);
  assign status_wr  = wr_en && (s_address == 3'd1);
  assign cpu_stop   = ctrl_wr & ~s_writedata[0];
  assign busy       = (state_q != StIdle);
  assign eff_period = (period_q == '0) ? {{PERIOD_W{1'b0}}, 1'b1} : {1'b0, period_q};
  assign cnt_inc    = {1'b0, cnt_q} + 1'b1;
  assign m_address  = 2'b00;
  assign irq        = done_q & irq_en_q;
  assign unused_wdata = ^s_writedata;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    set_done     = 1'b0;
    end_clear    = 1'b0;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_writedata  = wdata_q;

    case (state_q)
      StIdle: begin
        if (run_q && !cpu_stop) state_d = StStrobe;
      end
      StStrobe: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_writedata  = pat_q[idx_q];
        cnt_d        = '0;
        state_d      = StWait;
      end
      StWait: begin
        cnt_d = cnt_inc[PERIOD_W-1:0];
        if (cnt_inc >= eff_period) begin
          // idx wraps mod 4 so a shrunken LENGTH is always reached again.
          if (idx_q == length_q) begin
            state_d = StEnd;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = StStrobe;
          end
        end
      end
      StEnd: begin
        if (loop_q) begin
          idx_d   = '0;
          state_d = StStrobe;
        end else begin
          set_done  = 1'b1;
          end_clear = 1'b1;
          state_d   = StHalt;
        end
      end
`ifdef LED_SEQ_BLANK_ON_STOP_EN
      StBlank: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_writedata  = '0;
        state_d      = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase

    if (cpu_stop && busy) begin
      state_d   = (state_q == StHalt) ? StIdle : StHalt;
      set_done  = 1'b0;
      end_clear = 1'b0;
    end
    if (state_d == StIdle) idx_d = '0;
    wdata_d = m_writedata;
  end

  always_comb begin
    run_d    = run_q;
    loop_d   = loop_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    period_d = period_q;
    length_d = length_q;
    pat_d    = pat_q;

    if (end_clear) run_d = 1'b0;
    // A CPU write in the same cycle overrides the end-of-sequence clear.
    if (ctrl_wr) begin
      run_d    = s_writedata[0];
      loop_d   = s_writedata[1];
      irq_en_d = s_writedata[2];
    end
    if (status_wr && s_writedata[1]) done_d = 1'b0;
    if (set_done) done_d = 1'b1;
    if (wr_en && (s_address == 3'd2)) period_d = s_writedata[PERIOD_W-1:0];
    if (wr_en && (s_address == 3'd3)) length_d = s_writedata[1:0];
    if (wr_en && s_address[2]) pat_d[s_address[1:0]] = s_writedata[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      cnt_q    <= '0;
      wdata_q  <= '0;
      run_q    <= 1'b0;
      loop_q   <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      period_q <= '0;
      length_q <= '0;
      for (int i = 0; i < 4; i++) pat_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      wdata_q  <= wdata_d;
      run_q    <= run_d;
      loop_q   <= loop_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      period_q <= period_d;
      length_q <= length_d;
      pat_q    <= pat_d;
    end
  end

  always_comb begin
    s_readdata = '0;
    case (s_address)
      3'd0: s_readdata[2:0] = {irq_en_q, loop_q, run_q};
      3'd1: begin
        s_readdata[5:4] = idx_q;
        s_readdata[1]   = done_q;
        s_readdata[0]   = busy;
      end
      3'd2:    s_readdata[PERIOD_W-1:0] = period_q;
      3'd3:    s_readdata[1:0] = length_q;
      default: s_readdata[DATA_W-1:0] = pat_q[s_address[1:0]];
    endcase
  end

endmodule

// File: tb/tb_led_sequencer_ctrl.sv
// Randomized self-checking bench for led_sequencer_ctrl; expected PIO write schedule is
// computed arithmetically from period, step count and start cycle.
module tb_led_sequencer_ctrl;

  localparam int DW = 18;
`ifdef LED_SEQ_BLANK_ON_STOP_EN
  localparam int Blank = 1;
`else
  localparam int Blank = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    s_address = '0;
  logic          s_chipselect = 1'b0;
  logic          s_write_n = 1'b1;
  logic [31:0]   s_writedata = '0;
  logic [31:0]   s_readdata;
  logic [1:0]    m_address;
  logic          m_chipselect;
  logic          m_write_n;
  logic [DW-1:0] m_writedata;
  logic          irq;

  led_sequencer_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_address    (s_address),
    .s_chipselect (s_chipselect),
    .s_write_n    (s_write_n),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            obs_t[$];
  logic [DW-1:0] obs_d[$];
  logic [1:0]    obs_a[$];
  int            exp_t[$];
  logic [DW-1:0] exp_d[$];

  always @(negedge clk) begin
    if (m_chipselect && !m_write_n) begin
      obs_t.push_back(cyc);
      obs_d.push_back(m_writedata);
      obs_a.push_back(m_address);
    end
  end

  int n_checks = 0;
  int n_err = 0;
  int last_wr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drives one CSR write; last_wr is the cycle count just after the sampling edge.
  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    s_address = a; s_writedata = d; s_chipselect = 1'b1; s_write_n = 1'b0;
    @(negedge clk);
    s_chipselect = 1'b0; s_write_n = 1'b1;
    last_wr = cyc;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] v);
    s_address = a;
    #1;
    v = s_readdata;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  function automatic int wr_time(input int e, input int p, input int n, input int k);
    return e + 1 + k * (p + 1) + k / n;
  endfunction

  task automatic clear_obs();
    obs_t.delete(); obs_d.delete(); obs_a.delete(); exp_t.delete(); exp_d.delete();
  endtask

  task automatic compare_writes(input string tag);
    check_eq({tag, ".count"}, obs_t.size(), exp_t.size());
    for (int i = 0; i < obs_t.size() && i < exp_t.size(); i++) begin
      check_eq({tag, ".time"}, obs_t[i], exp_t[i]);
      check_eq({tag, ".data"}, obs_d[i], exp_d[i]);
      check_eq({tag, ".addr"}, obs_a[i], 0);
    end
  endtask

  logic [31:0]   v;
  logic [DW-1:0] pat [4];

  initial begin
    int e, s, p_raw, eff, n, lp, ie, k0, t_end, x;
    logic [31:0] r;

    repeat (3) @(negedge clk);
    check_eq("rst.cs", m_chipselect, 0);
    check_eq("rst.wn", m_write_n, 1);
    check_eq("rst.wdata", m_writedata, 0);
    check_eq("rst.irq", irq, 0);
    for (int a = 0; a < 8; a++) begin
      csr_rd(3'(a), v);
      check_eq("rst.csr", v, 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Single one-shot step of 0x3FFFF with period 4.
    csr_wr(3'd4, 32'h3FFFF);
    csr_wr(3'd2, 32'd4);
    csr_wr(3'd3, 32'd0);
    clear_obs();
    csr_wr(3'd0, 32'h1);
    e = last_wr;
    exp_t.push_back(e + 1); exp_d.push_back(18'h3FFFF);
    if (Blank) begin exp_t.push_back(e + 7); exp_d.push_back('0); end
    wait_cyc(e + 7 + Blank);
    compare_writes("single");
    csr_rd(3'd1, v); check_eq("single.status", v, 32'h2);
    check_eq("single.irq", irq, 0);
    csr_rd(3'd0, v); check_eq("single.ctrl", v, 0);
    csr_wr(3'd1, 32'h2);
    csr_rd(3'd1, v); check_eq("single.w1c", v, 0);

    // Randomized runs: one-shot to completion, or loop stopped by the CPU.
    for (int it = 0; it < 24; it++) begin
      p_raw = $urandom_range(0, 5);
      eff = (p_raw == 0) ? 1 : p_raw;
      n = $urandom_range(1, 4);
      lp = $urandom_range(0, 1);
      ie = $urandom_range(0, 1);
      for (int j = 0; j < 4; j++) begin
        r = $urandom;
        pat[j] = r[DW-1:0];
        csr_wr(3'(4 + j), r);
        csr_rd(3'(4 + j), v);
        check_eq("rnd.pat_rb", v, {14'd0, pat[j]});
      end
      r = $urandom; r[23:0] = 24'(p_raw);
      csr_wr(3'd2, r);
      csr_rd(3'd2, v); check_eq("rnd.period_rb", v, p_raw);
      r = $urandom; r[1:0] = 2'(n - 1);
      csr_wr(3'd3, r);
      csr_rd(3'd3, v); check_eq("rnd.length_rb", v, n - 1);
      clear_obs();
      csr_wr(3'd0, {29'd0, 1'(ie), 1'(lp), 1'b1});
      e = last_wr;
      if (lp) begin
        s = e + $urandom_range(3, 40);
        k0 = 0;
        while (wr_time(e, eff, n, k0) <= s - 1) begin
          exp_t.push_back(wr_time(e, eff, n, k0));
          exp_d.push_back(pat[k0 % n]);
          k0++;
        end
        k0--;
        wait_cyc(wr_time(e, eff, n, k0));
        csr_rd(3'd1, v); check_eq("loop.idx", v, ((k0 % n) << 4) | 1);
        wait_cyc(s - 1);
        csr_wr(3'd0, 32'h0);
        if (Blank) begin exp_t.push_back(s); exp_d.push_back('0); end
        csr_rd(3'd1, v); check_eq("stop.busy", v & 3, Blank);
        @(negedge clk);
        csr_rd(3'd1, v); check_eq("stop.idle", v & 3, 0);
        check_eq("stop.irq", irq, 0);
      end else begin
        t_end = wr_time(e, eff, n, n - 1) + eff + 2;
        for (int k = 0; k < n; k++) begin
          exp_t.push_back(wr_time(e, eff, n, k));
          exp_d.push_back(pat[k]);
        end
        if (Blank) begin exp_t.push_back(t_end); exp_d.push_back('0); end
        wait_cyc(t_end + Blank);
        csr_rd(3'd1, v); check_eq("shot.status", v, 32'h2);
        check_eq("shot.irq", irq, ie);
      end
      compare_writes(lp ? "loop" : "shot");
      if (exp_d.size() > 0) check_eq("hold.wdata", m_writedata, exp_d[exp_d.size() - 1]);
      csr_wr(3'd1, 32'h2);
      csr_rd(3'd1, v); check_eq("clr.status", v, 0);
      check_eq("clr.irq", irq, 0);
      repeat (2) @(negedge clk);
    end

    // PERIOD shortened from 100 to 3 in the middle of a long wait.
    csr_wr(3'd2, 32'd100);
    csr_wr(3'd3, 32'd0);
    csr_wr(3'd0, 32'h5);
    e = last_wr;
    wait_cyc(e + 52);
    csr_wr(3'd2, 32'd3);
    x = last_wr;
    @(negedge clk);
    csr_rd(3'd1, v); check_eq("pchg.end", v & 3, 1);
    @(negedge clk);
    csr_rd(3'd1, v); check_eq("pchg.done", v & 3, Blank ? 3 : 2);
    check_eq("pchg.irq", irq, 1);
    check_eq("pchg.cyc", cyc, x + 2);
    csr_wr(3'd1, 32'h2);
    repeat (2) @(negedge clk);

    // W1C landing on the END cycle: set wins.
    csr_wr(3'd2, 32'd2);
    csr_wr(3'd0, 32'h1);
    e = last_wr;
    wait_cyc(e + 4);
    csr_wr(3'd1, 32'h2);
    csr_rd(3'd1, v); check_eq("w1c_vs_end.done", v & 2, 2);
    csr_wr(3'd1, 32'h2);
    repeat (2) @(negedge clk);

    // Run re-asserted on the END cycle: CPU write wins.
    csr_wr(3'd0, 32'h1);
    e = last_wr;
    wait_cyc(e + 4);
    csr_wr(3'd0, 32'h1);
    csr_rd(3'd0, v); check_eq("rerun.ctrl", v, 1);
    csr_rd(3'd1, v); check_eq("rerun.done", v & 2, 2);
    csr_wr(3'd0, 32'h0);
    repeat (3) @(negedge clk);
    csr_rd(3'd1, v); check_eq("rerun.stopped", v & 1, 0);

    // Asynchronous reset during a strobe.
    csr_wr(3'd3, 32'd2);
    csr_wr(3'd0, 32'h3);
    e = last_wr;
    wait_cyc(e + 1);
    check_eq("prerst.cs", m_chipselect, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst.cs", m_chipselect, 0);
    check_eq("arst.wn", m_write_n, 1);
    check_eq("arst.irq", irq, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      csr_rd(3'(a), v);
      check_eq("arst.csr", v, 0);
    end
    repeat (4) @(negedge clk);
    check_eq("arst.quiet", m_chipselect, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
